// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the unified instruction/data memory port arbiter.
// Latency: none (types, constants and a pure function only).
// Backpressure: n/a.
package riscv_mem_pkg;

  // Arbiter sequencing states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Which requester owns the current transaction
  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;

  // Data access size codes (3 is illegal)
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // An access is misaligned when its byte lane is not a multiple of its size;
  // the illegal size code is folded in so one flag covers every error case.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = lane[0];
      SZ_W:    mis = |lane;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_gen.sv
// Byte-lane generator: byte strobes, replicated store data and misalignment flag.
// Latency: purely combinational.
// Backpressure: none; ports: size_i/lane_i/wdata_i in, wstrb_o/wdata_o/misalign_o out.
module mem_lane_gen
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);

  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = wdata_i;
    case (size_i)
      SZ_B: begin
        // Replicating the byte into every lane lets the strobe alone pick the target.
        wstrb_o = 4'b0001 << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        wstrb_o = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      SZ_W: begin
        wstrb_o = 4'b1111;
      end
      default: begin
        wstrb_o = 4'b0000;
      end
    endcase
  end

  assign misalign_o = misaligned(size_i, lane_i);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port fixed-latency memory between fetch and load/store.
// Latency: read ack at MEM_LAT+2, write ack at 3, error ack at 2 cycles after the request is seen idle.
// Backpressure: one transaction in flight; waiting requesters are held off via cpu_stall until their ack.
// Ports: if_* fetch side, d_* load/store side, mem_* memory macro side, cpu_stall to the core.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              cpu_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  gnt_t              last_q, last_d;
  gnt_t              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              d_err_q, d_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic [3:0]        lane_wstrb;
  logic [DATA_W-1:0] lane_wdata;
  logic              lane_mis;
  logic              if_vld, d_vld, pick_d;
  logic              unused_if_lane;

  // Fetches are always word aligned, so the low fetch address bits carry nothing.
  assign unused_if_lane = ^if_addr[1:0];

  mem_lane_gen u_lane (
    .size_i     (d_size),
    .lane_i     (d_addr[1:0]),
    .wdata_i    (d_wdata),
    .wstrb_o    (lane_wstrb),
    .wdata_o    (lane_wdata),
    .misalign_o (lane_mis)
  );

  // A requester still holds req during its own ack cycle; that req is the one
  // just completed, so it must not be granted a second time.
  assign if_vld = if_req & ~if_ack_q;
  assign d_vld  = d_req & ~d_ack_q;
  assign pick_d = d_vld & (~if_vld | (last_q == GNT_IF));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_d) begin
          gnt_d = GNT_D;
          if (lane_mis) begin
            state_d = ST_ERR;
          end else begin
            we_d        = d_we;
            mem_addr_d  = {d_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = lane_wdata;
            mem_wstrb_d = d_we ? lane_wstrb : 4'b0000;
            state_d     = ST_ISSUE;
          end
        end else if (if_vld) begin
          gnt_d       = GNT_IF;
          we_d        = 1'b0;
          mem_addr_d  = {if_addr[ADDR_W-1:2], 2'b00};
          mem_wdata_d = '0;
          mem_wstrb_d = 4'b0000;
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_RESP;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = (MEM_LAT == 1) ? ST_RESP : ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        // Read data lands exactly in this cycle; stores leave the read registers alone.
        if (!we_q) begin
          if (gnt_q == GNT_IF) begin
            if_rdata_d = mem_rdata;
          end else begin
            d_rdata_d = mem_rdata;
          end
        end
        if (gnt_q == GNT_IF) begin
          if_ack_d = 1'b1;
        end else begin
          d_ack_d = 1'b1;
        end
        last_d  = gnt_q;
        state_d = ST_IDLE;
      end

      ST_ERR: begin
        d_ack_d = 1'b1;
        d_err_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      last_q      <= GNT_IF;
      gnt_q       <= GNT_IF;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= 4'b0000;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en    = (state_q == ST_ISSUE);
  assign mem_we    = we_q & mem_en;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign cpu_stall = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 5);
  endfunction

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h0010_0093;
    return 32'(i) * 32'h9E37_79B9 + 32'h0000_1357;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic mem_load;

  logic        if_req[3];
  logic [31:0] if_addr[3];
  logic        if_ack[3];
  logic [31:0] if_rdata[3];
  logic        d_req[3];
  logic        d_we[3];
  logic [1:0]  d_size[3];
  logic [31:0] d_addr[3];
  logic [31:0] d_wdata[3];
  logic        d_ack[3];
  logic [31:0] d_rdata[3];
  logic        d_err[3];
  logic        cpu_stall[3];
  logic        mem_en[3];
  logic        mem_we[3];
  logic [31:0] mem_addr[3];
  logic [31:0] mem_wdata[3];
  logic [3:0]  mem_wstrb[3];
  logic [31:0] mem_rdata[3];

  // Instance 0: MEM_LAT=2, instance 1: MEM_LAT=1, instance 2: MEM_LAT=5
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(lat_of(g))) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ack(if_ack[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_size(d_size[g]), .d_addr(d_addr[g]),
      .d_wdata(d_wdata[g]), .d_ack(d_ack[g]), .d_rdata(d_rdata[g]), .d_err(d_err[g]),
      .cpu_stall(cpu_stall[g]), .mem_en(mem_en[g]), .mem_we(mem_we[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_wstrb(mem_wstrb[g]),
      .mem_rdata(mem_rdata[g])
    );
  end

  // Memory macros: byte-strobed writes, reads return exactly MEM_LAT cycles after mem_en.
  logic [31:0] mem[3][256];
  logic        pv[3][16];
  logic [31:0] pd[3][16];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mem_load) begin
        for (int i = 0; i < 256; i++) mem[k][i] <= init_word(i);
        for (int s = 0; s < 16; s++) pv[k][s] <= 1'b0;
      end else begin
        for (int s = 15; s > 0; s--) begin
          pv[k][s] <= pv[k][s-1];
          pd[k][s] <= pd[k][s-1];
        end
        pv[k][0] <= mem_en[k] & ~mem_we[k];
        pd[k][0] <= mem[k][mem_addr[k][9:2]];
        if (mem_en[k] && mem_we[k]) begin
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[k][b]) mem[k][mem_addr[k][9:2]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++)
      mem_rdata[k] = pv[k][lat_of(k)-1] ? pd[k][lat_of(k)-1] : 32'hDEAD_BEEF;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic fetch(input int k, input logic [31:0] a, output int ack_c, output int en_c,
                       output logic [31:0] ma, output logic [31:0] rd, output int st_hi,
                       output logic st_ack);
    if_req[k] = 1'b1; if_addr[k] = a;
    ack_c = -1; en_c = -1; ma = '0; rd = '0; st_hi = 0; st_ack = 1'b1;
    #1;
    if (cpu_stall[k]) st_hi++;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_en[k] && en_c < 0) begin en_c = c; ma = mem_addr[k]; end
      if (if_ack[k]) begin ack_c = c; rd = if_rdata[k]; st_ack = cpu_stall[k]; break; end
      if (cpu_stall[k]) st_hi++;
    end
    if_req[k] = 1'b0;
    @(negedge clk);
  endtask

  task automatic dtxn(input int k, input logic we, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, output int ack_c, output int en_n,
                      output logic [31:0] ma, output logic [3:0] st, output logic [31:0] mw,
                      output logic mwe, output logic er, output logic [31:0] rd);
    d_req[k] = 1'b1; d_we[k] = we; d_size[k] = sz; d_addr[k] = a; d_wdata[k] = wd;
    ack_c = -1; en_n = 0; ma = '0; st = '0; mw = '0; mwe = 1'b0; er = 1'b0; rd = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_en[k]) begin en_n++; ma = mem_addr[k]; st = mem_wstrb[k]; mw = mem_wdata[k]; mwe = mem_we[k]; end
      if (d_ack[k]) begin ack_c = c; er = d_err[k]; rd = d_rdata[k]; break; end
    end
    d_req[k] = 1'b0;
    @(negedge clk);
  endtask

  task automatic race(input logic exp_d_first, input string nm);
    logic got_if, got_d, seen, first_d;
    got_if = 1'b0; got_d = 1'b0; seen = 1'b0; first_d = 1'b0;
    if_req[0] = 1'b1; if_addr[0] = 32'h300;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_size[0] = 2'd2; d_addr[0] = 32'h200;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (d_ack[0] && !got_d) begin got_d = 1'b1; d_req[0] = 1'b0; if (!seen) first_d = 1'b1; seen = 1'b1; end
      if (if_ack[0] && !got_if) begin got_if = 1'b1; if_req[0] = 1'b0; seen = 1'b1; end
      if (got_if && got_d) break;
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    chk({nm, " data first"}, 32'(first_d), 32'(exp_d_first));
    chk({nm, " both acked"}, {30'd0, got_if, got_d}, 32'd3);
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] maddr;
    logic [3:0]  strb;
    logic [31:0] mwdata;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  logic [31:0] ref_mem[256];

  initial begin : main
    vec_t vt[10];
    int ack_c, en_c, st_hi, en_n, t, n_rnd, diffs;
    logic [31:0] ma, rd, mw;
    logic [3:0] st;
    logic mwe, er, st_ack;
    logic act, exp_is_d, exp_err, exp_we, last_d, e_if, e_d, drop_if, drop_d;
    logic pi, pdq, gd;
    int exp_ack, lat, a_int, sz_int;
    logic [31:0] exp_dat;

    vt[0] = '{1'b1, 2'd0, 32'h103, 32'h0000_00AB, 1'b0, 32'h100, 4'b1000, 32'hABAB_ABAB, 32'h0, 3};
    vt[1] = '{1'b1, 2'd1, 32'h102, 32'h0000_1234, 1'b0, 32'h100, 4'b1100, 32'h1234_1234, 32'h0, 3};
    vt[2] = '{1'b1, 2'd1, 32'h100, 32'h0000_BEEF, 1'b0, 32'h100, 4'b0011, 32'hBEEF_BEEF, 32'h0, 3};
    vt[3] = '{1'b1, 2'd2, 32'h104, 32'hCAFE_F00D, 1'b0, 32'h104, 4'b1111, 32'hCAFE_F00D, 32'h0, 3};
    vt[4] = '{1'b1, 2'd0, 32'h100, 32'h0000_0011, 1'b0, 32'h100, 4'b0001, 32'h1111_1111, 32'h0, 3};
    vt[5] = '{1'b0, 2'd1, 32'h101, 32'h0,         1'b1, 32'h0,   4'b0000, 32'h0, 32'h0, 2};
    vt[6] = '{1'b0, 2'd2, 32'h102, 32'h0,         1'b1, 32'h0,   4'b0000, 32'h0, 32'h0, 2};
    vt[7] = '{1'b1, 2'd3, 32'h100, 32'h5555_5555, 1'b1, 32'h0,   4'b0000, 32'h0, 32'h0, 2};
    vt[8] = '{1'b0, 2'd2, 32'h104, 32'h0,         1'b0, 32'h104, 4'b0000, 32'h0, 32'hCAFE_F00D, 4};
    vt[9] = '{1'b0, 2'd0, 32'h101, 32'h0,         1'b0, 32'h100, 4'b0000, 32'h0, 32'h1234_BE11, 4};

    for (int k = 0; k < 3; k++) begin
      if_req[k] = 1'b0; if_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_size[k] = 2'd0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    rst = 1'b1; mem_load = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset ctrl", {26'd0, if_ack[0], d_ack[0], d_err[0], mem_en[0], mem_we[0], cpu_stall[0]}, 32'd0);
    chk("reset mem_addr", mem_addr[0], 32'd0);
    chk("reset mem_wdata", mem_wdata[0], 32'd0);
    chk("reset mem_wstrb", {28'd0, mem_wstrb[0]}, 32'd0);
    chk("reset if_rdata", if_rdata[0], 32'd0);
    chk("reset d_rdata", d_rdata[0], 32'd0);
    mem_load = 1'b0; rst = 1'b0;

    // Round-robin: data first out of reset, then the opposite of whoever completed last.
    race(1'b1, "race after reset");
    dtxn(0, 1'b0, 2'd2, 32'h0, 32'h0, ack_c, en_n, ma, st, mw, mwe, er, rd);
    race(1'b0, "race after data");
    fetch(0, 32'h8, ack_c, en_c, ma, rd, st_hi, st_ack);
    race(1'b1, "race after fetch");

    fetch(0, 32'h10, ack_c, en_c, ma, rd, st_hi, st_ack);
    chk("fetch ack cycle", 32'(ack_c), 32'd4);
    chk("fetch mem_en cycle", 32'(en_c), 32'd1);
    chk("fetch mem_addr", ma, 32'h10);
    chk("fetch if_rdata", rd, 32'h0010_0093);
    chk("fetch stall cycles", 32'(st_hi), 32'd4);
    chk("fetch stall at ack", {31'd0, st_ack}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      dtxn(0, vt[i].we, vt[i].size, vt[i].addr, vt[i].wdata, ack_c, en_n, ma, st, mw, mwe, er, rd);
      chk($sformatf("vec%0d ack cycle", i), 32'(ack_c), 32'(vt[i].lat));
      chk($sformatf("vec%0d d_err", i), {31'd0, er}, {31'd0, vt[i].err});
      chk($sformatf("vec%0d mem_en count", i), 32'(en_n), vt[i].err ? 32'd0 : 32'd1);
      if (!vt[i].err) begin
        chk($sformatf("vec%0d mem_addr", i), ma, vt[i].maddr);
        chk($sformatf("vec%0d wstrb", i), {28'd0, st}, {28'd0, vt[i].strb});
        chk($sformatf("vec%0d mem_we", i), {31'd0, mwe}, {31'd0, vt[i].we});
        if (vt[i].we) chk($sformatf("vec%0d mem_wdata", i), mw, vt[i].mwdata);
        else          chk($sformatf("vec%0d d_rdata", i), rd, vt[i].rdata);
      end
    end

    fetch(1, 32'h40, ack_c, en_c, ma, rd, st_hi, st_ack);
    chk("lat1 ack cycle", 32'(ack_c), 32'd3);
    chk("lat1 if_rdata", rd, init_word(16));
    fetch(2, 32'h40, ack_c, en_c, ma, rd, st_hi, st_ack);
    chk("lat5 ack cycle", 32'(ack_c), 32'd7);
    chk("lat5 if_rdata", rd, init_word(16));

    // Reset while the fetch is waiting on memory
    if_req[0] = 1'b1; if_addr[0] = 32'h20;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid rst ctrl", {28'd0, if_ack[0], d_ack[0], mem_en[0], mem_we[0]}, 32'd0);
    chk("mid rst if_rdata", if_rdata[0], 32'd0);
    chk("mid rst d_rdata", d_rdata[0], 32'd0);
    chk("mid rst mem_addr", mem_addr[0], 32'd0);
    if_req[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    n_rnd = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (if_ack[0] || d_ack[0]) n_rnd++;
    end
    chk("acks after reset release", 32'(n_rnd), 32'd0);
    fetch(0, 32'h20, ack_c, en_c, ma, rd, st_hi, st_ack);
    chk("post-reset fetch ack cycle", 32'(ack_c), 32'd4);
    chk("post-reset fetch data", rd, init_word(8));

    // Randomized traffic against a transaction-level model
    rst = 1'b1; mem_load = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    repeat (2) @(negedge clk);
    mem_load = 1'b0; rst = 1'b0;
    act = 1'b0; last_d = 1'b0; exp_ack = 0; exp_is_d = 1'b0; exp_err = 1'b0; exp_we = 1'b0;
    exp_dat = '0; n_rnd = 0;
    for (t = 0; t < 3000; t++) begin
      e_if = act && (exp_ack == t) && !exp_is_d;
      e_d  = act && (exp_ack == t) && exp_is_d;
      if (if_ack[0] || e_if) begin
        chk("rnd if_ack", {31'd0, if_ack[0]}, {31'd0, e_if});
        if (e_if) chk("rnd if_rdata", if_rdata[0], exp_dat);
      end
      if (d_ack[0] || e_d) begin
        chk("rnd d_ack", {31'd0, d_ack[0]}, {31'd0, e_d});
        if (e_d) chk("rnd d_err", {31'd0, d_err[0]}, {31'd0, exp_err});
        if (e_d && !exp_err && !exp_we) chk("rnd d_rdata", d_rdata[0], exp_dat);
      end
      if (act && exp_ack == t) begin
        act = 1'b0; n_rnd++;
        if (!exp_err) last_d = exp_is_d;
      end
      drop_if = 1'b0; drop_d = 1'b0;
      if (if_ack[0]) begin if_req[0] = 1'b0; drop_if = 1'b1; end
      if (d_ack[0])  begin d_req[0] = 1'b0;  drop_d = 1'b1; end
      if (t < 2970) begin
        if (!if_req[0] && !drop_if && $urandom_range(0, 3) == 0) begin
          if_req[0] = 1'b1; if_addr[0] = 32'($urandom_range(0, 1023));
        end
        if (!d_req[0] && !drop_d && $urandom_range(0, 2) == 0) begin
          d_req[0] = 1'b1; d_we[0] = 1'($urandom_range(0, 1)); d_size[0] = 2'($urandom_range(0, 3));
          d_addr[0] = 32'($urandom_range(0, 1023)); d_wdata[0] = $urandom;
        end
      end
      if (!act) begin
        pi = if_req[0]; pdq = d_req[0];
        if (pi || pdq) begin
          gd = pdq && (!pi || !last_d);
          exp_is_d = gd; exp_err = 1'b0; exp_we = 1'b0;
          if (gd) begin
            a_int = int'(d_addr[0]); sz_int = int'(d_size[0]);
            exp_we  = d_we[0];
            exp_err = (sz_int == 3) || ((a_int % (1 << sz_int)) != 0);
            if (exp_err) lat = 2;
            else if (exp_we) begin
              lat = 3;
              for (int b = 0; b < (1 << sz_int); b++)
                ref_mem[((a_int + b) >> 2) & 255][8*((a_int + b) % 4) +: 8] = d_wdata[0][8*b +: 8];
            end else begin
              lat = lat_of(0) + 2;
              exp_dat = ref_mem[(a_int >> 2) & 255];
            end
          end else begin
            lat = lat_of(0) + 2;
            exp_dat = ref_mem[(int'(if_addr[0]) >> 2) & 255];
          end
          exp_ack = t + lat; act = 1'b1;
        end
      end
      @(negedge clk);
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rnd enough transactions", {31'd0, n_rnd > 300}, 32'd1);
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[0][i] !== ref_mem[i]) diffs++;
    chk("rnd memory image", 32'(diffs), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
